// File: rtl/change_dispenser.sv
// Change dispenser: pays a returned balance greedily as Rs.20/10/5 coins, one timed
// solenoid pulse per coin, while tracking per-denomination hopper inventory.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned INV_W        = 8,
    parameter int unsigned INIT_INV5    = 20,
    parameter int unsigned INIT_INV10   = 20,
    parameter int unsigned INIT_INV20   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bal_valid,
    output logic             bal_ready,
    input  logic [4:0]       balance,
    input  logic             refill,
    input  logic [INV_W-1:0] refill_n5,
    input  logic [INV_W-1:0] refill_n10,
    input  logic [INV_W-1:0] refill_n20,
    output logic             coin5_out,
    output logic             coin10_out,
    output logic             coin20_out,
    output logic             busy,
    output logic             done,
    output logic             short_pay,
    output logic [4:0]       short_amt,
    output logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] inv10,
    output logic [INV_W-1:0] inv20
);

    localparam int unsigned AMT_W   = 5;
    localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         coin_q, coin_d;      // {20, 10, 5}
    logic               done_q, done_d;
    logic               short_pay_q, short_pay_d;
    logic [AMT_W-1:0]   short_amt_q, short_amt_d;
    logic [INV_W-1:0]   inv5_q, inv5_d;
    logic [INV_W-1:0]   inv10_q, inv10_d;
    logic [INV_W-1:0]   inv20_q, inv20_d;
    logic               bal_ready_q, bal_ready_d;
    logic               busy_q, busy_d;

    // State register; reset aborts any payout in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            cnt_q       <= '0;
            coin_q      <= '0;
            done_q      <= 1'b0;
            short_pay_q <= 1'b0;
            short_amt_q <= '0;
            inv5_q      <= INV_W'(INIT_INV5);
            inv10_q     <= INV_W'(INIT_INV10);
            inv20_q     <= INV_W'(INIT_INV20);
            bal_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            coin_q      <= coin_d;
            done_q      <= done_d;
            short_pay_q <= short_pay_d;
            short_amt_q <= short_amt_d;
            inv5_q      <= inv5_d;
            inv10_q     <= inv10_d;
            inv20_q     <= inv20_d;
            bal_ready_q <= bal_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        coin_d      = coin_q;
        done_d      = 1'b0;
        short_pay_d = short_pay_q;
        short_amt_d = short_amt_q;
        inv5_d      = inv5_q;
        inv10_d     = inv10_q;
        inv20_d     = inv20_q;

        case (state_q)
            S_IDLE: begin
                if (refill) begin
                    inv5_d  = refill_n5;
                    inv10_d = refill_n10;
                    inv20_d = refill_n20;
                end
                if (bal_valid && bal_ready_q) begin
                    rem_d       = balance;
                    short_pay_d = 1'b0;
                    short_amt_d = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                // Largest denomination first, skipping empty hoppers.
                cnt_d = '0;
                if (rem_q >= AMT_W'(20) && inv20_q != '0) begin
                    rem_d   = rem_q - AMT_W'(20);
                    inv20_d = inv20_q - INV_W'(1);
                    coin_d  = 3'b100;
                    state_d = S_PULSE;
                end else if (rem_q >= AMT_W'(10) && inv10_q != '0) begin
                    rem_d   = rem_q - AMT_W'(10);
                    inv10_d = inv10_q - INV_W'(1);
                    coin_d  = 3'b010;
                    state_d = S_PULSE;
                end else if (rem_q >= AMT_W'(5) && inv5_q != '0) begin
                    rem_d   = rem_q - AMT_W'(5);
                    inv5_d  = inv5_q - INV_W'(1);
                    coin_d  = 3'b001;
                    state_d = S_PULSE;
                end else begin
                    done_d      = 1'b1;
                    short_pay_d = (rem_q != '0);
                    short_amt_d = rem_q;
                    state_d     = S_DONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    coin_d  = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                coin_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        bal_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    assign bal_ready  = bal_ready_q;
    assign busy       = busy_q;
    assign coin5_out  = coin_q[0];
    assign coin10_out = coin_q[1];
    assign coin20_out = coin_q[2];
    assign done       = done_q;
    assign short_pay  = short_pay_q;
    assign short_amt  = short_amt_q;
    assign inv5       = inv5_q;
    assign inv10      = inv10_q;
    assign inv20      = inv20_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed table, hand corner sequences, and random
// payouts checked against a transaction-level greedy payout model.
module tb_change_dispenser;

    localparam int P  = 4;
    localparam int G  = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          bal_valid;
    logic          bal_ready;
    logic [4:0]    balance;
    logic          refill;
    logic [IW-1:0] refill_n5, refill_n10, refill_n20;
    logic          coin5_out, coin10_out, coin20_out;
    logic          busy, done, short_pay;
    logic [4:0]    short_amt;
    logic [IW-1:0] inv5, inv10, inv20;

    change_dispenser #(
        .PULSE_CYCLES(P), .GAP_CYCLES(G), .INV_W(IW),
        .INIT_INV5(20), .INIT_INV10(20), .INIT_INV20(10)
    ) dut (
        .clk(clk), .reset(reset),
        .bal_valid(bal_valid), .bal_ready(bal_ready), .balance(balance),
        .refill(refill), .refill_n5(refill_n5), .refill_n10(refill_n10), .refill_n20(refill_n20),
        .coin5_out(coin5_out), .coin10_out(coin10_out), .coin20_out(coin20_out),
        .busy(busy), .done(done), .short_pay(short_pay), .short_amt(short_amt),
        .inv5(inv5), .inv10(inv10), .inv20(inv20)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;
    int m5, m10, m20;   // model inventory

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One payout: model computes coin list, trace and leftovers; DUT is observed each cycle.
    task automatic run_txn(input logic [4:0] bal, input bit do_refill,
                           input int n5, input int n10, input int n20, input bit poke,
                           output int o5, output int o10, output int o20, output int oshort);
        int rem;
        int coins[$];
        int exp_tr[$];
        int obs_tr[$];
        int bad_busy;
        int mism;
        int prev;
        int code;
        int idx;

        if (do_refill) begin m5 = n5; m10 = n10; m20 = n20; end
        rem = bal;
        for (int k = 0; k < 32; k++) begin
            if (rem >= 20 && m20 > 0)      begin rem -= 20; m20--; coins.push_back(4); end
            else if (rem >= 10 && m10 > 0) begin rem -= 10; m10--; coins.push_back(2); end
            else if (rem >= 5 && m5 > 0)   begin rem -= 5;  m5--;  coins.push_back(1); end
            else break;
        end
        exp_tr.push_back(0);
        foreach (coins[i]) begin
            repeat (P) exp_tr.push_back(coins[i]);
            repeat (G) exp_tr.push_back(0);
            exp_tr.push_back(0);
        end

        @(posedge clk); #1;
        chk("ready_idle", 32'(bal_ready), 1);
        bal_valid  = 1'b1;
        balance    = bal;
        refill     = do_refill;
        refill_n5  = IW'(n5);
        refill_n10 = IW'(n10);
        refill_n20 = IW'(n20);
        @(posedge clk); #1;
        bal_valid = 1'b0;
        refill    = 1'b0;
        if (poke) begin
            bal_valid  = 1'b1;
            balance    = 5'd31;
            refill     = 1'b1;
            refill_n5  = '0;
            refill_n10 = '0;
            refill_n20 = '0;
        end

        o5 = 0; o10 = 0; o20 = 0;
        bad_busy = 0;
        prev = 0;
        idx = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            code = {coin20_out, coin10_out, coin5_out};
            if (done) break;
            obs_tr.push_back(code);
            if (bal_ready !== 1'b0 || busy !== 1'b1) bad_busy++;
            if (code != 0 && code != prev) begin
                if (code == 1) o5++;
                else if (code == 2) o10++;
                else if (code == 4) o20++;
            end
            prev = code;
            @(posedge clk); #1;
            idx++;
        end
        bal_valid = 1'b0;
        refill    = 1'b0;

        mism = 0;
        foreach (exp_tr[i]) begin
            if (i >= obs_tr.size()) mism++;
            else if (obs_tr[i] != exp_tr[i]) mism++;
        end
        oshort = short_amt;
        chk("done_seen",   32'(done), 1);
        chk("done_lat",    32'(idx), 32'(exp_tr.size()));
        chk("coin_trace",  32'(mism), 0);
        chk("busy_ready",  32'(bad_busy), 0);
        chk("short_pay",   32'(short_pay), 32'(rem != 0));
        chk("short_amt",   32'(short_amt), 32'(rem));
        chk("inv5",        32'(inv5), 32'(m5));
        chk("inv10",       32'(inv10), 32'(m10));
        chk("inv20",       32'(inv20), 32'(m20));
        @(posedge clk); #1;
        chk("back_idle", 32'({done, bal_ready, busy}), 32'(3'b010));
        chk("held_amt",  32'(short_amt), 32'(rem));
    endtask

    typedef struct {
        bit       rf;
        int       n5, n10, n20;
        logic [4:0] bal;
        int       e5, e10, e20;
        int       eshort;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int o5, o10, o20, osh;
        int cnt;

        reset = 1'b1; bal_valid = 1'b0; balance = '0; refill = 1'b0;
        refill_n5 = '0; refill_n10 = '0; refill_n20 = '0;
        m5 = 20; m10 = 20; m20 = 10;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coins", 32'({coin20_out, coin10_out, coin5_out}), 0);
        chk("rst_flags", 32'({done, short_pay, busy, bal_ready}), 32'(4'b0001));
        chk("rst_amt",   32'(short_amt), 0);
        chk("rst_inv",   32'({inv5, inv10, inv20}), 32'({8'd20, 8'd20, 8'd10}));
        reset = 1'b0;

        // {refill, n5, n10, n20, balance, exp 5s, exp 10s, exp 20s, exp short}
        vecs[0] = '{1'b0, 0, 0, 0, 5'd15, 1, 1, 0, 0};
        vecs[1] = '{1'b1, 5, 5, 0, 5'd20, 0, 2, 0, 0};
        vecs[2] = '{1'b0, 0, 0, 0, 5'd7,  1, 0, 0, 2};
        vecs[3] = '{1'b1, 0, 0, 0, 5'd25, 0, 0, 0, 25};
        vecs[4] = '{1'b0, 0, 0, 0, 5'd0,  0, 0, 0, 0};
        vecs[5] = '{1'b1, 3, 3, 3, 5'd31, 0, 1, 1, 1};
        vecs[6] = '{1'b1, 1, 0, 1, 5'd30, 1, 0, 1, 5};
        vecs[7] = '{1'b0, 0, 0, 0, 5'd4,  0, 0, 0, 4};
        foreach (vecs[i]) begin
            run_txn(vecs[i].bal, vecs[i].rf, vecs[i].n5, vecs[i].n10, vecs[i].n20, 1'b0,
                    o5, o10, o20, osh);
            chk($sformatf("vec%0d_n5", i),  32'(o5),  32'(vecs[i].e5));
            chk($sformatf("vec%0d_n10", i), 32'(o10), 32'(vecs[i].e10));
            chk($sformatf("vec%0d_n20", i), 32'(o20), 32'(vecs[i].e20));
            chk($sformatf("vec%0d_short", i), 32'(osh), 32'(vecs[i].eshort));
        end

        // Requests and refills during a payout must be ignored.
        run_txn(5'd20, 1'b1, 4, 4, 4, 1'b1, o5, o10, o20, osh);
        chk("poke_n20", 32'(o20), 1);

        // Reset in the second pulse cycle aborts the payout.
        run_txn(5'd0, 1'b1, 5, 5, 5, 1'b0, o5, o10, o20, osh);
        @(posedge clk); #1;
        bal_valid = 1'b1; balance = 5'd15;
        @(posedge clk); #1;
        bal_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pulse2_before_rst", 32'(coin10_out), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_coins", 32'({coin20_out, coin10_out, coin5_out}), 0);
        chk("abort_flags", 32'({done, short_pay, busy, bal_ready}), 32'(4'b0001));
        chk("abort_inv",   32'({inv5, inv10, inv20}), 32'({8'd20, 8'd20, 8'd10}));
        m5 = 20; m10 = 20; m20 = 10;
        cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if ({coin20_out, coin10_out, coin5_out, busy, done} != 0) cnt++;
        end
        chk("abort_quiet", 32'(cnt), 0);

        // Randomized payouts with occasional small refills to drain hoppers.
        for (int r = 0; r < 40; r++) begin
            bit rf;
            bit pk;
            rf = ($urandom_range(0, 3) == 0);
            pk = ($urandom_range(0, 4) == 0);
            run_txn(5'($urandom_range(0, 31)), rf,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), pk,
                    o5, o10, o20, osh);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
